temp_filter: RTL and testbench
==============================

# temp_filter

Sample-conditioning stage between `temp_sensor` and `tmon_slave`. Captures each raw 8-bit reading on `tick`, keeps a ring buffer of the last DEPTH samples, and produces a registered moving average plus running min/max. A hysteretic alarm FSM flags hot/cold conditions. `tmon_slave` reads the conditioned values instead of the raw `temp`.

## Interface
- `DEPTH`, 4: samples averaged; power of two, 2..16.
- `HYST`, 2: alarm hysteresis in degrees (unsigned, 0..15).
- `Clock` in 1: system clock; all state changes on posedge.
- `Reset` in 1: asynchronous, active-low; clears all state immediately.
- `tick` in 1: sample strobe from `temp_sensor`; one sample per cycle it is high.
- `temp` in 8: raw unsigned temperature, valid when `tick`=1.
- `hi_thresh` in 8: hot threshold, unsigned, level input.
- `lo_thresh` in 8: cold threshold, unsigned; `lo_thresh` < `hi_thresh` required, else alarm behaviour is undefined.
- `clr_minmax` in 1: synchronous clear of min/max tracking.
- `avg` out 8: moving average of the last DEPTH samples.
- `avg_valid` out 1: high once DEPTH samples have been captured since reset.
- `sample_done` out 1: one-cycle pulse when `avg` has been updated.
- `min_temp` out 8: lowest raw sample since reset or clear.
- `max_temp` out 8: highest raw sample since reset or clear.
- `hot` out 1: alarm, average above the hot band.
- `cold` out 1: alarm, average below the cold band.

## Operation
- Ring buffer: DEPTH×8 entries; `wr_ptr` has log2(DEPTH) bits and wraps silently. `count` saturates at DEPTH.
- On a sampled `tick`, `temp` is written to `buf[wr_ptr]` and `wr_ptr` increments.
  - If `count` < DEPTH: `sum += temp`, `count++`.
  - Else: `sum = sum + temp − buf[wr_ptr]`, where `buf[wr_ptr]` is the old (evicted) value.
- `sum` is 8+log2(DEPTH) bits and never overflows.
- `avg = sum >> log2(DEPTH)`, truncating. It is computed only when `count`=DEPTH; otherwise `avg` holds 0.
- Min/max:
  - On a sampled `tick`: `min_temp = min(min_temp, temp)` and `max_temp = max(max_temp, temp)`.
  - `clr_minmax` alone loads `min_temp`=8'hFF and `max_temp`=8'h00.
  - `clr_minmax` and `tick` in the same cycle load `min_temp`=`max_temp`=`temp`.
- Alarm FSM, states NORMAL, HOT, COLD. It is evaluated only in the cycle `sample_done`=1, using the new `avg`.
  - NORMAL → HOT if `avg` ≥ `hi_thresh`.
  - NORMAL → COLD if `avg` ≤ `lo_thresh`.
  - HOT → COLD if `avg` ≤ `lo_thresh` (checked first).
  - HOT → NORMAL if `avg` ≤ `hi_thresh` − HYST, saturating at 0.
  - COLD → HOT if `avg` ≥ `hi_thresh` (checked first).
  - COLD → NORMAL if `avg` ≥ `lo_thresh` + HYST, saturating at 255.
  - Otherwise the FSM holds state.
- Alarm outputs are registered: `hot` = (state==HOT), `cold` = (state==COLD). Both are never high together.
- Threshold changes take effect at the next `sample_done`; no retroactive evaluation.

## Timing
- Reset values (`Reset`=0): `avg`=0, `avg_valid`=0, `sample_done`=0, `min_temp`=8'hFF, `max_temp`=8'h00, `hot`=0, `cold`=0, state NORMAL. Pointer, count, sum and buffer are all zero.
- Reset asserted mid-operation discards all history; the next DEPTH ticks refill from empty.
- Tick sampled at edge N:
  - Buffer, sum, count and min/max update at edge N.
  - `avg`, `avg_valid` and `sample_done` (one cycle) update at edge N+1.
  - The FSM, `hot` and `cold` update at edge N+2.
- `sample_done` fires only when `count`=DEPTH after edge N. No pulse is generated during fill.
- Back-to-back ticks (every cycle) are fully supported at one sample per cycle with no drops. The pipeline stages are independent registers.
- `tick` is ignored while `Reset`=0.

## Test plan
- Reset, then ticks with temp 10,20,30,40 (DEPTH=4) → `avg_valid` rises 1 cycle after the 4th tick, `avg`=25, `sample_done` pulses once, `min_temp`=10, `max_temp`=40.
- Continue with a tick of temp 50 → buffer holds 20,30,40,50, `avg`=35. Six more ticks of 0 → `avg`=0, and wrap-around of `wr_ptr` is exercised.
- `hi_thresh`=100, HYST=2, ticks of 100 ×4 → `hot`=1 two cycles after the 4th tick. Ticks of 99 ×4 → `hot` stays 1 (99 > 98). Ticks of 98 ×4 → `hot`=0.
- `lo_thresh`=5 with state HOT, ticks of 0 ×4 → direct HOT→COLD transition, `cold`=1, `hot`=0. Ticks of 7 ×4 → NORMAL.
- Ticks of 255 ×4 → `avg`=255, no sum overflow. `clr_minmax` concurrent with a tick of 77 → `min_temp`=`max_temp`=77.
- `Reset` pulled low between the 2nd and 3rd tick → all outputs return to reset values immediately. After release, 4 new ticks of 8 → `avg`=8 and no pre-reset data contributes.

Source files
------------

// File: rtl/temp_filter.sv
// Sample conditioning between temp_sensor and tmon_slave: moving average over a
// ring of the last DEPTH readings, running min/max, and a hysteretic hot/cold alarm.
module temp_filter #(
   parameter int DEPTH = 4,
   parameter int HYST  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [7:0] temp,
   input  logic [7:0] hi_thresh,
   input  logic [7:0] lo_thresh,
   input  logic       clr_minmax,
   output logic [7:0] avg,
   output logic       avg_valid,
   output logic       sample_done,
   output logic [7:0] min_temp,
   output logic [7:0] max_temp,
   output logic       hot,
   output logic       cold
);

   localparam int PW = $clog2(DEPTH);
   localparam int SW = 8 + PW;

   localparam logic [1:0] ST_NORMAL = 2'd0;
   localparam logic [1:0] ST_HOT    = 2'd1;
   localparam logic [1:0] ST_COLD   = 2'd2;

   logic [7:0]    ring_reg [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW:0]   count_reg;
   logic [SW-1:0] sum_reg;
   logic [SW-1:0] sum_next;
   logic          tick_d_reg;
   logic          full;
   logic [7:0]    evicted;

   logic [7:0]    avg_reg;
   logic          avg_valid_reg;
   logic          sample_done_reg;
   logic [7:0]    min_reg;
   logic [7:0]    max_reg;

   logic [1:0]    state_reg;
   logic [1:0]    state_next;
   logic          hot_reg;
   logic          cold_reg;
   logic [8:0]    hi_minus_wide;
   logic [8:0]    lo_plus_wide;
   logic [7:0]    hi_minus;
   logic [7:0]    lo_plus;

   assign full    = (count_reg == (PW+1)'(DEPTH));
   assign evicted = ring_reg[wr_ptr_reg];

   // Once the ring is full the slot about to be overwritten is the oldest sample.
   always_comb begin
      sum_next = sum_reg + SW'(temp);
      if (full) begin
         sum_next = sum_reg + SW'(temp) - SW'(evicted);
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ring
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ring_reg[gi] <= 8'd0;
            end else if (tick && (wr_ptr_reg == PW'(gi))) begin
               ring_reg[gi] <= temp;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         sum_reg    <= '0;
         tick_d_reg <= 1'b0;
      end else begin
         tick_d_reg <= tick;
         if (tick) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            sum_reg    <= sum_next;
            if (!full) begin
               count_reg <= count_reg + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         avg_reg         <= 8'd0;
         avg_valid_reg   <= 1'b0;
         sample_done_reg <= 1'b0;
      end else begin
         sample_done_reg <= tick_d_reg && full;
         if (tick_d_reg && full) begin
            avg_reg       <= sum_reg[SW-1:PW];
            avg_valid_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_reg <= 8'hFF;
         max_reg <= 8'h00;
      end else if (clr_minmax && tick) begin
         min_reg <= temp;
         max_reg <= temp;
      end else if (clr_minmax) begin
         min_reg <= 8'hFF;
         max_reg <= 8'h00;
      end else if (tick) begin
         if (temp < min_reg) min_reg <= temp;
         if (temp > max_reg) max_reg <= temp;
      end
   end

   // Band edges saturate so small thresholds or large HYST never wrap.
   assign hi_minus_wide = {1'b0, hi_thresh} - 9'(HYST);
   assign lo_plus_wide  = {1'b0, lo_thresh} + 9'(HYST);
   assign hi_minus      = hi_minus_wide[8] ? 8'd0   : hi_minus_wide[7:0];
   assign lo_plus       = lo_plus_wide[8]  ? 8'hFF  : lo_plus_wide[7:0];

   always_comb begin
      state_next = state_reg;
      if (sample_done_reg) begin
         case (state_reg)
            ST_NORMAL: begin
               if (avg_reg >= hi_thresh)      state_next = ST_HOT;
               else if (avg_reg <= lo_thresh) state_next = ST_COLD;
            end
            ST_HOT: begin
               if (avg_reg <= lo_thresh)      state_next = ST_COLD;
               else if (avg_reg <= hi_minus)  state_next = ST_NORMAL;
            end
            ST_COLD: begin
               if (avg_reg >= hi_thresh)      state_next = ST_HOT;
               else if (avg_reg >= lo_plus)   state_next = ST_NORMAL;
            end
            default: state_next = ST_NORMAL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_NORMAL;
         hot_reg   <= 1'b0;
         cold_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         hot_reg   <= (state_next == ST_HOT);
         cold_reg  <= (state_next == ST_COLD);
      end
   end

   assign avg         = avg_reg;
   assign avg_valid   = avg_valid_reg;
   assign sample_done = sample_done_reg;
   assign min_temp    = min_reg;
   assign max_temp    = max_reg;
   assign hot         = hot_reg;
   assign cold        = cold_reg;

endmodule

// File: tb/tb_temp_filter.sv
// Scoreboard bench for temp_filter: a reference ring predicts every average and
// alarm state, and the monitor pops predictions as sample_done pulses arrive.
module tb_temp_filter;

   localparam int DEPTH = 4;
   localparam int HYST  = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic [7:0] temp;
   logic [7:0] hi_thresh;
   logic [7:0] lo_thresh;
   logic       clr_minmax;
   logic [7:0] avg;
   logic       avg_valid;
   logic       sample_done;
   logic [7:0] min_temp;
   logic [7:0] max_temp;
   logic       hot;
   logic       cold;

   int checks = 0;
   int passed = 0;
   int pulses = 0;
   int hist[$];
   int exp_q[$];
   int emin = 255;
   int emax = 0;
   int mstate = 0;
   int pend_state = 0;
   bit pend = 0;

   always #5 clk = ~clk;

   temp_filter #(.DEPTH(DEPTH), .HYST(HYST)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .temp(temp),
      .hi_thresh(hi_thresh), .lo_thresh(lo_thresh), .clr_minmax(clr_minmax),
      .avg(avg), .avg_valid(avg_valid), .sample_done(sample_done),
      .min_temp(min_temp), .max_temp(max_temp), .hot(hot), .cold(cold)
   );

   // Monitor: alarm checked one cycle after the sample_done that decides it.
   always @(negedge clk) begin
      int e, hm, lp;
      if (!rst_n) begin
         pend   = 0;
         mstate = 0;
      end else begin
         if (pend) begin
            checks++;
            if (hot !== (pend_state == 1) || cold !== (pend_state == 2))
               $display("FAIL alarm: hot=%b cold=%b required state %0d (0=normal 1=hot 2=cold)",
                        hot, cold, pend_state);
            else passed++;
            pend = 0;
         end
         if (sample_done) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL sample_done: unexpected pulse, avg=%0d", avg);
            end else begin
               e = exp_q.pop_front();
               if (avg !== 8'(e) || avg_valid !== 1'b1)
                  $display("FAIL avg: got %0d valid=%b, required %0d valid=1", avg, avg_valid, e);
               else passed++;
               hm = (hi_thresh >= HYST) ? hi_thresh - HYST : 0;
               lp = (lo_thresh + HYST > 255) ? 255 : lo_thresh + HYST;
               case (mstate)
                  0: if (e >= hi_thresh) mstate = 1; else if (e <= lo_thresh) mstate = 2;
                  1: if (e <= lo_thresh) mstate = 2; else if (e <= hm) mstate = 0;
                  default: if (e >= hi_thresh) mstate = 1; else if (e >= lp) mstate = 0;
               endcase
               pend_state = mstate;
               pend = 1;
               $display("sample avg=%0d expected=%0d state=%0d", avg, e, mstate);
            end
         end
      end
   end

   task automatic drive_tick(input int v, input bit clr);
      int s;
      tick = 1'b1;
      temp = 8'(v);
      clr_minmax = clr;
      hist.push_back(v);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      if (hist.size() == DEPTH) begin
         s = 0;
         foreach (hist[i]) s += hist[i];
         exp_q.push_back(s / DEPTH);
      end
      if (clr) begin
         emin = v;
         emax = v;
      end else begin
         if (v < emin) emin = v;
         if (v > emax) emax = v;
      end
      @(posedge clk);
      #1;
      tick = 1'b0;
      clr_minmax = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      hist.delete();
      exp_q.delete();
      emin = 255;
      emax = 0;
   endtask

   task automatic check_minmax(input string name);
      checks++;
      if (min_temp !== 8'(emin) || max_temp !== 8'(emax))
         $display("FAIL %s: min=%0d max=%0d, required min=%0d max=%0d", name, min_temp, max_temp, emin, emax);
      else passed++;
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (avg !== 8'd0 || avg_valid !== 1'b0 || sample_done !== 1'b0 || min_temp !== 8'hFF ||
          max_temp !== 8'h00 || hot !== 1'b0 || cold !== 1'b0)
         $display("FAIL %s: avg=%0d valid=%b done=%b min=%0d max=%0d hot=%b cold=%b, required 0 0 0 255 0 0 0",
                  name, avg, avg_valid, sample_done, min_temp, max_temp, hot, cold);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick = 1'b1;
      temp = 8'd99;
      clr_minmax = 1'b0;
      hi_thresh = 8'd100;
      lo_thresh = 8'd5;
      model_reset();
      idle(3);
      check_reset_outputs("reset");
      tick = 1'b0;
      rst_n = 1'b1;
      idle(2);
      check_reset_outputs("after_release");
   endtask

   task automatic test_fill();
      pulses = 0;
      drive_tick(10, 0);
      drive_tick(20, 0);
      drive_tick(30, 0);
      drive_tick(40, 0);
      checks++;
      if (avg_valid !== 1'b0) $display("FAIL fill_valid_early: avg_valid=%b required 0", avg_valid);
      else passed++;
      idle(1);
      checks++;
      if (avg_valid !== 1'b1 || avg !== 8'd25)
         $display("FAIL fill_valid: avg_valid=%b avg=%0d required 1 25", avg_valid, avg);
      else passed++;
      idle(3);
      checks++;
      if (pulses !== 1) $display("FAIL fill_pulses: got %0d required 1", pulses);
      else passed++;
      check_minmax("fill_minmax");
   endtask

   task automatic test_wrap();
      drive_tick(50, 0);
      idle(1);
      checks++;
      if (avg !== 8'd35) $display("FAIL wrap_avg35: got %0d required 35", avg);
      else passed++;
      repeat (6) drive_tick(0, 0);
      idle(4);
      checks++;
      if (avg !== 8'd0) $display("FAIL wrap_avg0: got %0d required 0", avg);
      else passed++;
      check_minmax("wrap_minmax");
   endtask

   task automatic test_hot();
      repeat (4) drive_tick(100, 0);
      idle(1);
      checks++;
      if (hot !== 1'b0) $display("FAIL hot_latency: hot=%b required 0 one cycle after", hot);
      else passed++;
      idle(1);
      checks++;
      if (hot !== 1'b1) $display("FAIL hot_set: hot=%b required 1", hot);
      else passed++;
      repeat (4) drive_tick(99, 0);
      idle(4);
      checks++;
      if (hot !== 1'b1) $display("FAIL hot_hold: hot=%b required 1", hot);
      else passed++;
      repeat (4) drive_tick(98, 0);
      idle(4);
      checks++;
      if (hot !== 1'b0) $display("FAIL hot_release: hot=%b required 0", hot);
      else passed++;
   endtask

   task automatic test_cold();
      repeat (4) drive_tick(100, 0);
      idle(4);
      hi_thresh = 8'd20;
      lo_thresh = 8'd5;
      repeat (4) drive_tick(0, 0);
      idle(4);
      checks++;
      if (cold !== 1'b1 || hot !== 1'b0)
         $display("FAIL hot_to_cold: hot=%b cold=%b required 0 1", hot, cold);
      else passed++;
      repeat (4) drive_tick(7, 0);
      idle(4);
      checks++;
      if (cold !== 1'b0 || hot !== 1'b0)
         $display("FAIL cold_to_normal: hot=%b cold=%b required 0 0", hot, cold);
      else passed++;
   endtask

   task automatic test_saturate_clear();
      repeat (4) drive_tick(255, 0);
      idle(4);
      checks++;
      if (avg !== 8'd255) $display("FAIL avg255: got %0d required 255", avg);
      else passed++;
      clr_minmax = 1'b1;
      emin = 255;
      emax = 0;
      idle(1);
      clr_minmax = 1'b0;
      check_minmax("clr_alone");
      drive_tick(77, 1);
      check_minmax("clr_with_tick");
      idle(4);
   endtask

   task automatic test_reset_mid();
      drive_tick(60, 0);
      idle(3);
      drive_tick(61, 0);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("reset_mid");
      idle(1);
      rst_n = 1'b1;
      idle(1);
      repeat (4) drive_tick(8, 0);
      idle(1);
      checks++;
      if (avg !== 8'd8 || avg_valid !== 1'b1)
         $display("FAIL refill_avg: avg=%0d valid=%b required 8 1", avg, avg_valid);
      else passed++;
      idle(3);
      check_minmax("refill_minmax");
   endtask

   task automatic test_back_to_back();
      int budget;
      hi_thresh = 8'd150;
      lo_thresh = 8'd60;
      idle(2);
      for (int i = 0; i < 24; i++) begin
         drive_tick($urandom_range(0, 255), 0);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      budget = 0;
      while (exp_q.size() != 0 && budget < 50) begin
         idle(1);
         budget++;
      end
      checks++;
      if (exp_q.size() != 0) $display("FAIL drain: %0d averages never produced, required 0", exp_q.size());
      else passed++;
      idle(3);
      check_minmax("random_minmax");
   endtask

   initial begin
      test_reset();
      test_fill();
      test_wrap();
      test_hot();
      test_cold();
      test_saturate_clear();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
